// File: rtl/core_pkg.sv
// Shared types and default widths for the core's program sequencer.
package core_pkg;

  localparam int unsigned PC_W_DEF    = 7;
  localparam int unsigned INSTR_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/pc_next_unit.sv
// Next-PC selection: branch target when taken, otherwise PC+1 wrapping at 2**PC_W.
module pc_next_unit
  import core_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_i,
  input  logic            branch_cond_i,
  input  logic            zero_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic            taken_o
);

  always_comb begin
    taken_o   = branch_i | (branch_cond_i & zero_i);
    pc_next_o = taken_o ? target_i : pc_i + PC_W'(1);
  end

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle program sequencer: PC, instruction register and fetch/execute/memory-wait/halt FSM
// with start/done handshake, end-address stop and cycle watchdog.
module prog_sequencer
  import core_pkg::*;
#(
  parameter int unsigned     PC_W       = PC_W_DEF,
  parameter int unsigned     INSTR_W    = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] END_PC     = '1,
  parameter int unsigned     MAX_CYCLES = 4096,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] inst_in,
  input  logic               halt,
  input  logic               branch,
  input  logic               branch_cond,
  input  logic               zero,
  input  logic [PC_W-1:0]    target,
  input  logic               reg_write,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               mem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               rf_we,
  output logic               mem_req,
  output logic               mem_we,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [63:0] WD_LAST = 64'(MAX_CYCLES) - 64'd1;

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_nxt;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               taken, busy_w, wdog, commit;

  pc_next_unit #(.PC_W(PC_W)) u_pc_next (
    .pc_i          (pc_q),
    .branch_i      (branch),
    .branch_cond_i (branch_cond),
    .zero_i        (zero),
    .target_i      (target),
    .pc_next_o     (pc_nxt),
    .taken_o       (taken)
  );

  always_comb begin
    busy_w = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM_WAIT);
    wdog   = (MAX_CYCLES != 0) && busy_w && (64'(cnt_q) == WD_LAST);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    rf_we     = 1'b0;
    commit    = 1'b0;

    if (busy_w && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d   = FETCH;
          pc_d      = RESET_PC;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      FETCH: begin
        if (wdog) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end else begin
          ir_d    = inst_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (halt) begin
          state_d = HALTED;
        end else if (wdog) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end else if (mem_read || mem_write) begin
          state_d   = MEM_WAIT;
          mem_req_d = 1'b1;
          mem_we_d  = mem_write;
        end else begin
          commit = 1'b1;
          rf_we  = reg_write;
        end
      end
      MEM_WAIT: begin
        if (wdog) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (mem_ack) begin
          commit    = 1'b1;
          rf_we     = mem_read & reg_write;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // EXEC and MEM_WAIT share one commit path so END_PC stop and PC update stay identical.
    if (commit) begin
      if ((pc_q == END_PC) && !taken) begin
        state_d = HALTED;
      end else begin
        pc_d    = pc_nxt;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    pc          = pc_q;
    ir          = ir_q;
    mem_req     = mem_req_q;
    mem_we      = mem_we_q;
    busy        = busy_w;
    done        = (state_q == HALTED);
    timeout     = timeout_q;
    cycle_count = cnt_q;
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench: instance A uses defaults, B has MAX_CYCLES=10, C has a 4-bit counter and no watchdog.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [8:0] inst_in;
  logic       halt, branch, branch_cond, zero, reg_write, mem_read, mem_write, mem_ack;
  logic [6:0] target;

  logic [6:0]  pc_a, pc_b, pc_c;
  logic [8:0]  ir_a, ir_b, ir_c;
  logic        rf_we_a, rf_we_b, rf_we_c, mem_req_a, mem_req_b, mem_req_c;
  logic        mem_we_a, mem_we_b, mem_we_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, timeout_a, timeout_b, timeout_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prog_sequencer u_a (
    .clk(clk), .reset(reset), .start(start), .inst_in(inst_in), .halt(halt), .branch(branch),
    .branch_cond(branch_cond), .zero(zero), .target(target), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack), .pc(pc_a), .ir(ir_a),
    .rf_we(rf_we_a), .mem_req(mem_req_a), .mem_we(mem_we_a), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .cycle_count(cnt_a)
  );

  prog_sequencer #(.MAX_CYCLES(10)) u_b (
    .clk(clk), .reset(reset), .start(start), .inst_in(inst_in), .halt(halt), .branch(branch),
    .branch_cond(branch_cond), .zero(zero), .target(target), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack), .pc(pc_b), .ir(ir_b),
    .rf_we(rf_we_b), .mem_req(mem_req_b), .mem_we(mem_we_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .cycle_count(cnt_b)
  );

  prog_sequencer #(.MAX_CYCLES(0), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .start(start), .inst_in(inst_in), .halt(halt), .branch(branch),
    .branch_cond(branch_cond), .zero(zero), .target(target), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack), .pc(pc_c), .ir(ir_c),
    .rf_we(rf_we_c), .mem_req(mem_req_c), .mem_we(mem_we_c), .busy(busy_c), .done(done_c),
    .timeout(timeout_c), .cycle_count(cnt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic h, input logic b, input logic bc, input logic z,
                        input logic [6:0] tgt, input logic rw, input logic mr, input logic mw);
    halt = h; branch = b; branch_cond = bc; zero = z;
    target = tgt; reg_write = rw; mem_read = mr; mem_write = mw;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inst_in = '0; mem_ack = 1'b0;
    set_op(0, 0, 0, 0, 7'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({pc_a, ir_a, rf_we_a, mem_req_a, mem_we_a, busy_a, done_a, timeout_a, cnt_a} !== '0) begin
      n_fail++; $display("FAIL rst_vals: got %h want 0", {pc_a, ir_a, rf_we_a, mem_req_a, mem_we_a, busy_a, done_a, timeout_a, cnt_a}); end
    reset = 1'b0;
    tick();
    n_chk++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle_hold: busy=%b done=%b want 0 0", busy_a, done_a); end
  endtask

  task automatic test_basic();
    set_op(0, 0, 0, 0, 7'd0, 1, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inst_in = 9'(9'h100 + i);
      if (i == 3) halt = 1'b1;
      #1;
      n_chk++; if (pc_a !== 7'(i) || rf_we_a !== 1'b0 || busy_a !== 1'b1) begin
        n_fail++; $display("FAIL basic_fetch: pc=%0d rf_we=%b busy=%b want pc=%0d rf_we=0 busy=1", pc_a, rf_we_a, busy_a, i); end
      tick();
      n_chk++; if (ir_a !== 9'(9'h100 + i) || rf_we_a !== (i < 3)) begin
        n_fail++; $display("FAIL basic_exec: ir=%h rf_we=%b want ir=%h rf_we=%b", ir_a, rf_we_a, 9'h100 + i, i < 3); end
      tick();
    end
    n_chk++; if (done_a !== 1'b1 || busy_a !== 1'b0 || pc_a !== 7'd3 || cnt_a !== 16'd8 || timeout_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: done=%b busy=%b pc=%0d cnt=%0d to=%b want 1 0 3 8 0", done_a, busy_a, pc_a, cnt_a, timeout_a); end
    halt = 1'b0;
  endtask

  task automatic test_load();
    int req_n, rf_n, we_n;
    set_op(0, 0, 0, 0, 7'd0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    mem_read = 1'b1; reg_write = 1'b1;
    #1;
    n_chk++; if (pc_a !== 7'd5) begin n_fail++; $display("FAIL load_pc: got %0d want 5", pc_a); end
    tick();
    n_chk++; if (mem_req_a !== 1'b0 || rf_we_a !== 1'b0) begin
      n_fail++; $display("FAIL load_exec: mem_req=%b rf_we=%b want 0 0", mem_req_a, rf_we_a); end
    req_n = 0; rf_n = 0; we_n = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_ack = (k == 2);
      #1;
      req_n += int'(mem_req_a); rf_n += int'(rf_we_a); we_n += int'(mem_we_a);
    end
    tick();
    mem_ack = 1'b0;
    n_chk++; if (req_n != 3 || rf_n != 1 || we_n != 0) begin
      n_fail++; $display("FAIL load_counts: req=%0d rf_we=%0d we=%0d want 3 1 0", req_n, rf_n, we_n); end
    n_chk++; if (mem_req_a !== 1'b0 || pc_a !== 7'd6 || rf_we_a !== 1'b0) begin
      n_fail++; $display("FAIL load_after: mem_req=%b pc=%0d rf_we=%b want 0 6 0", mem_req_a, pc_a, rf_we_a); end
    mem_read = 1'b0; mem_write = 1'b1;
    tick(); tick();
    mem_ack = 1'b1;
    #1;
    n_chk++; if (mem_req_a !== 1'b1 || mem_we_a !== 1'b1 || rf_we_a !== 1'b0) begin
      n_fail++; $display("FAIL store_wait: mem_req=%b mem_we=%b rf_we=%b want 1 1 0", mem_req_a, mem_we_a, rf_we_a); end
    tick();
    mem_ack = 1'b0; mem_write = 1'b0; reg_write = 1'b0; halt = 1'b1;
    #1;
    n_chk++; if (pc_a !== 7'd7 || mem_req_a !== 1'b0 || mem_we_a !== 1'b0) begin
      n_fail++; $display("FAIL store_after: pc=%0d mem_req=%b mem_we=%b want 7 0 0", pc_a, mem_req_a, mem_we_a); end
    tick(); tick();
    n_chk++; if (done_a !== 1'b1 || pc_a !== 7'd7) begin
      n_fail++; $display("FAIL load_done: done=%b pc=%0d want 1 7", done_a, pc_a); end
    halt = 1'b0;
  endtask

  task automatic test_branch();
    set_op(0, 0, 1, 1, 7'h40, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_chk++; if (pc_a !== 7'h40) begin n_fail++; $display("FAIL br_cond_taken: pc=%h want 40", pc_a); end
    zero = 1'b0;
    tick(); tick();
    n_chk++; if (pc_a !== 7'h41) begin n_fail++; $display("FAIL br_cond_not: pc=%h want 41", pc_a); end
    set_op(0, 1, 0, 0, 7'd127, 0, 0, 0);
    tick(); tick();
    n_chk++; if (pc_a !== 7'd127) begin n_fail++; $display("FAIL br_to_end: pc=%0d want 127", pc_a); end
    set_op(0, 1, 0, 0, 7'h10, 1, 0, 0);
    tick();
    n_chk++; if (rf_we_a !== 1'b1) begin n_fail++; $display("FAIL br_end_commit: rf_we=%b want 1", rf_we_a); end
    tick();
    n_chk++; if (pc_a !== 7'h10 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL br_end_override: pc=%h busy=%b done=%b want 10 1 0", pc_a, busy_a, done_a); end
    set_op(1, 0, 0, 0, 7'd0, 0, 0, 0);
    tick(); tick();
    n_chk++; if (done_a !== 1'b1 || pc_a !== 7'h10) begin
      n_fail++; $display("FAIL br_halt: done=%b pc=%h want 1 10", done_a, pc_a); end
    halt = 1'b0;
  endtask

  task automatic test_end_pc();
    set_op(0, 1, 0, 0, 7'd120, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    set_op(0, 0, 0, 0, 7'd0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++; if (pc_a !== 7'(120 + i) || busy_a !== 1'b1) begin
        n_fail++; $display("FAIL end_fetch: pc=%0d busy=%b want %0d 1", pc_a, busy_a, 120 + i); end
      tick();
      n_chk++; if (rf_we_a !== 1'b1) begin n_fail++; $display("FAIL end_commit: rf_we=%b want 1 at pc %0d", rf_we_a, 120 + i); end
      tick();
    end
    n_chk++; if (done_a !== 1'b1 || busy_a !== 1'b0 || pc_a !== 7'd127 || timeout_a !== 1'b0) begin
      n_fail++; $display("FAIL end_halt: done=%b busy=%b pc=%0d to=%b want 1 0 127 0", done_a, busy_a, pc_a, timeout_a); end
  endtask

  task automatic test_watchdog();
    set_op(0, 0, 0, 0, 7'd0, 1, 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    n_chk++; if (mem_req_b !== 1'b1 || done_b !== 1'b0 || busy_b !== 1'b1 || cnt_b !== 16'd9) begin
      n_fail++; $display("FAIL wd_before: mem_req=%b done=%b busy=%b cnt=%0d want 1 0 1 9", mem_req_b, done_b, busy_b, cnt_b); end
    tick();
    n_chk++; if (done_b !== 1'b1 || timeout_b !== 1'b1 || mem_req_b !== 1'b0 || busy_b !== 1'b0 || cnt_b !== 16'd10 || pc_b !== 7'd0) begin
      n_fail++; $display("FAIL wd_fire: done=%b to=%b mem_req=%b busy=%b cnt=%0d pc=%0d want 1 1 0 0 10 0", done_b, timeout_b, mem_req_b, busy_b, cnt_b, pc_b); end
    start = 1'b1; tick(); start = 1'b0;
    n_chk++; if (done_b !== 1'b0 || timeout_b !== 1'b0 || cnt_b !== 16'd0 || busy_b !== 1'b1) begin
      n_fail++; $display("FAIL wd_restart: done=%b to=%b cnt=%0d busy=%b want 0 0 0 1", done_b, timeout_b, cnt_b, busy_b); end
    n_chk++; if (busy_a !== 1'b1 || mem_req_a !== 1'b1 || cnt_a !== 16'd11 || pc_a !== 7'd0) begin
      n_fail++; $display("FAIL start_ignored_busy: busy=%b mem_req=%b cnt=%0d pc=%0d want 1 1 11 0", busy_a, mem_req_a, cnt_a, pc_a); end
  endtask

  task automatic test_reset_mid();
    repeat (10) tick();
    n_chk++; if (cnt_a !== 16'd21 || cnt_c !== 4'd15 || mem_req_a !== 1'b1) begin
      n_fail++; $display("FAIL cnt_sat: cnt_a=%0d cnt_c=%0d mem_req=%b want 21 15 1", cnt_a, cnt_c, mem_req_a); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++; if ({pc_a, ir_a, rf_we_a, mem_req_a, mem_we_a, busy_a, done_a, timeout_a, cnt_a} !== '0 || cnt_c !== 4'd0) begin
      n_fail++; $display("FAIL rst_async: got %h cnt_c=%0d want 0 0", {pc_a, ir_a, rf_we_a, mem_req_a, mem_we_a, busy_a, done_a, timeout_a, cnt_a}, cnt_c); end
    @(negedge clk);
    reset = 1'b0;
    set_op(1, 0, 0, 0, 7'd0, 0, 0, 0);
    tick();
    n_chk++; if (busy_a !== 1'b0 || mem_req_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_post_idle: busy=%b mem_req=%b want 0 0", busy_a, mem_req_a); end
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_chk++; if (done_a !== 1'b1 || cnt_a !== 16'd2 || pc_a !== 7'd0) begin
      n_fail++; $display("FAIL idle_start_halt: done=%b cnt=%0d pc=%0d want 1 2 0", done_a, cnt_a, pc_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_branch();
    test_end_pc();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
